// File: rtl/hub75_pkg.sv
// Shared HUB75 definitions: panel geometry, capture-memory address layout
// {plane,row,col}, pixel type and the drain-side state type.
package hub75_pkg;

  localparam int unsigned NUM_COLS  = 64;
  localparam int unsigned ROW_W     = 5;
  localparam int unsigned BIT_DEPTH = 4;
  localparam int unsigned PLANE_W   = (BIT_DEPTH > 1) ? $clog2(BIT_DEPTH) : 1;
  localparam int unsigned COL_W     = $clog2(NUM_COLS);
  localparam int unsigned CNT_W     = $clog2(NUM_COLS + 1);
  localparam int unsigned ADDR_W    = PLANE_W + ROW_W + COL_W;

  typedef logic [5:0]         pixel_t;   // {rgb0, rgb1}
  typedef logic [PLANE_W-1:0] plane_t;
  typedef logic [ROW_W-1:0]   row_t;
  typedef logic [COL_W-1:0]   col_t;
  typedef logic [CNT_W-1:0]   cnt_t;
  typedef logic [ADDR_W-1:0]  addr_t;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    DONE
  } drain_state_t;

  // Capture / frame memory address, identical to the driver's read order.
  function automatic addr_t pack_addr(input plane_t plane, input row_t r, input col_t col);
    return {plane, r, col};
  endfunction

endpackage

// File: rtl/hub75_in_sync.sv
// Multi-bit synchronizer for the panel inputs plus edge detection of the
// shift clock and latch. All bits share one chain so they stay aligned.
module hub75_in_sync #(
  parameter int unsigned W             = 14,
  parameter int unsigned STAGES        = 2,
  parameter int unsigned CLK_BIT       = 13,
  parameter int unsigned LATCH_BIT     = 12,
  parameter bit          LATCH_ACT_LOW = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] q,
  output logic [W-1:0] q_d,
  output logic         shift_ev,
  output logic         latch_ev
);

  localparam int unsigned DEPTH = (STAGES < 2) ? 2 : STAGES;

  logic [DEPTH*W-1:0] chain;

  // Synchronizer chain plus one extra stage for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '0;
      q_d   <= '0;
    end else begin
      chain <= {chain[(DEPTH-1)*W-1:0], din};
      q_d   <= chain[DEPTH*W-1 -: W];
    end
  end

  assign q        = chain[DEPTH*W-1 -: W];
  assign shift_ev = q[CLK_BIT] & ~q_d[CLK_BIT];
  assign latch_ev = LATCH_ACT_LOW ? (~q[LATCH_BIT] &  q_d[LATCH_BIT])
                                  : ( q[LATCH_BIT] & ~q_d[LATCH_BIT]);

endmodule

// File: rtl/hub75_line_capture.sv
// HUB75 receive-side line capture: rebuilds shifted lines from the sampled
// panel interface and writes them to a {plane,row,col} capture memory.
// Optional macro HUB75_ONTIME_EN adds the ontime/ontime_valid ports that
// report the synced noe-low cycle count between latch events.
module hub75_line_capture
  import hub75_pkg::*;
#(
  parameter bit          LATCH_ACT_LOW = 1'b1,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               lp_clk,
  input  logic               latch,
  input  logic               noe,
  input  logic [ROW_W-1:0]   row,
  input  logic [2:0]         rgb0,
  input  logic [2:0]         rgb1,
  input  logic               clr_err,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [5:0]         wr_data,
  output logic               line_done,
  output logic [ROW_W-1:0]   line_row,
  output logic [PLANE_W-1:0] line_plane,
  output logic               err_short,
  output logic               err_long,
  output logic               err_overrun
`ifdef HUB75_ONTIME_EN
  ,
  output logic [15:0]        ontime,
  output logic               ontime_valid
`endif
);

  localparam int unsigned SW = 3 + ROW_W + 6;

  logic [SW-1:0] s_q, s_d;
  logic          shift_raw, latch_raw;

  hub75_in_sync #(
    .W            (SW),
    .STAGES       (SYNC_STAGES),
    .CLK_BIT      (SW - 1),
    .LATCH_BIT    (SW - 2),
    .LATCH_ACT_LOW(LATCH_ACT_LOW)
  ) u_sync (
    .clk     (clk),
    .rst     (rst),
    .din     ({lp_clk, latch, noe, row, rgb0, rgb1}),
    .q       (s_q),
    .q_d     (s_d),
    .shift_ev(shift_raw),
    .latch_ev(latch_raw)
  );

  logic   shift_ev, latch_ev, s_noe;
  row_t   s_row;
  pixel_t shift_pix;
  logic   unused_sync;

  assign shift_ev    = shift_raw & en;
  assign latch_ev    = latch_raw & en;
  assign s_row       = s_q[6 +: ROW_W];
  assign s_noe       = s_q[6 + ROW_W];
  assign shift_pix   = s_d[5:0];   // data held before the lp_clk rise
  assign unused_sync = ^{s_d[SW-1:6], s_q[SW-1:SW-2], s_q[5:0]};

  pixel_t       line_buf [2][NUM_COLS];
  logic         fill_sel, drain_sel, have_prev;
  cnt_t         col_cnt, drain_len, eff_cnt;
  col_t         drain_col;
  row_t         prev_row, drain_row;
  plane_t       cur_plane, drain_plane, next_plane;
  drain_state_t state, state_nxt;
  logic         at_full, handoff, overrun;

  assign at_full    = (col_cnt == CNT_W'(NUM_COLS));
  // Column count after a same-cycle shift, so a latch sees the shift first.
  assign eff_cnt    = (shift_ev && !at_full) ? col_cnt + 1'b1 : col_cnt;
  assign handoff    = latch_ev && (state == IDLE);
  assign overrun    = latch_ev && (state != IDLE);
  assign next_plane = (have_prev && (s_row == prev_row))
                      ? ((cur_plane == PLANE_W'(BIT_DEPTH - 1)) ? '0 : cur_plane + 1'b1)
                      : '0;

  // Fill buffer: direct column writes, then a sliding window once full.
  always_ff @(posedge clk) begin
    if (shift_ev) begin
      if (!at_full) begin
        line_buf[fill_sel][col_cnt[COL_W-1:0]] <= shift_pix;
      end else begin
        for (int unsigned i = 0; i < NUM_COLS - 1; i++)
          line_buf[fill_sel][COL_W'(i)] <= line_buf[fill_sel][COL_W'(i + 1)];
        line_buf[fill_sel][COL_W'(NUM_COLS - 1)] <= shift_pix;
      end
    end
  end

  // Fill control, buffer handover, plane tracking, sticky errors, line status.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_cnt     <= '0;
      fill_sel    <= 1'b0;
      drain_sel   <= 1'b0;
      have_prev   <= 1'b0;
      prev_row    <= '0;
      cur_plane   <= '0;
      drain_row   <= '0;
      drain_plane <= '0;
      drain_len   <= '0;
      drain_col   <= '0;
      err_short   <= 1'b0;
      err_long    <= 1'b0;
      err_overrun <= 1'b0;
      line_done   <= 1'b0;
      line_row    <= '0;
      line_plane  <= '0;
    end else begin
      if (!en || latch_ev)        col_cnt <= '0;
      else if (shift_ev && !at_full) col_cnt <= col_cnt + 1'b1;

      if (handoff) begin
        fill_sel    <= ~fill_sel;
        drain_sel   <= fill_sel;
        drain_row   <= s_row;
        drain_plane <= next_plane;
        drain_len   <= eff_cnt;
        prev_row    <= s_row;
        cur_plane   <= next_plane;
        have_prev   <= 1'b1;
      end

      err_short   <= (err_short & ~clr_err) | (latch_ev && (eff_cnt != CNT_W'(NUM_COLS)));
      err_long    <= (err_long & ~clr_err) | (shift_ev && at_full);
      err_overrun <= (err_overrun & ~clr_err) | overrun;

      line_done <= (state == DONE);
      if (state == DONE) begin
        line_row   <= drain_row;
        line_plane <= drain_plane;
      end

      drain_col <= (state == WRITE) ? drain_col + 1'b1 : '0;
    end
  end

  // Drain state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Drain next-state and write port; columns beyond the shifted count read as 0.
  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    case (state)
      IDLE:  if (handoff) state_nxt = WRITE;
      WRITE: begin
        wr_en   = 1'b1;
        wr_addr = pack_addr(drain_plane, drain_row, drain_col);
        wr_data = (CNT_W'(drain_col) < drain_len) ? line_buf[drain_sel][drain_col] : '0;
        if (drain_col == COL_W'(NUM_COLS - 1)) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef HUB75_ONTIME_EN
  logic [15:0] on_cnt;

  // Saturating count of noe-low cycles, reported and cleared on each latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      on_cnt       <= '0;
      ontime       <= '0;
      ontime_valid <= 1'b0;
    end else begin
      ontime_valid <= latch_ev;
      if (latch_ev) begin
        ontime <= on_cnt;
        on_cnt <= '0;
      end else if (!s_noe && (on_cnt != '1)) begin
        on_cnt <= on_cnt + 1'b1;
      end
    end
  end
`else
  logic unused_noe;
  assign unused_noe = s_noe;
`endif

endmodule

// File: tb/tb_hub75_line_capture.sv
// Self-checking bench for hub75_line_capture: a line-level model predicts
// every capture write and line completion; literal checks pin the model.
`timescale 1ns/1ps
module tb_hub75_line_capture;

  localparam int NCOL = 64;

  logic        clk = 1'b0, rst = 1'b1, en = 1'b0;
  logic        lp_clk = 1'b0, latch = 1'b1, noe = 1'b1, clr_err = 1'b0;
  logic [4:0]  row = '0;
  logic [2:0]  rgb0 = '0, rgb1 = '0;
  logic        wr_en, line_done, err_short, err_long, err_overrun;
  logic [12:0] wr_addr;
  logic [5:0]  wr_data;
  logic [4:0]  line_row;
  logic [1:0]  line_plane;
`ifdef HUB75_ONTIME_EN
  logic [15:0] ontime;
  logic        ontime_valid;
  int          on_pulses = 0;
  int          last_ontime = 0;
`endif

  hub75_line_capture #(.LATCH_ACT_LOW(1'b1), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .en(en), .lp_clk(lp_clk), .latch(latch), .noe(noe),
    .row(row), .rgb0(rgb0), .rgb1(rgb1), .clr_err(clr_err),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .line_done(line_done),
    .line_row(line_row), .line_plane(line_plane), .err_short(err_short),
    .err_long(err_long), .err_overrun(err_overrun)
`ifdef HUB75_ONTIME_EN
    , .ontime(ontime), .ontime_valid(ontime_valid)
`endif
  );

  always #5 clk = ~clk;

  int          tests = 0, fails = 0, cyc = 0;
  logic [5:0]  pq[$];          // pixels of the line being shifted
  logic [18:0] exp_q[$];       // {addr, data} expected writes
  logic [6:0]  exp_lines[$];   // {row, plane} expected completions
  logic [5:0]  mem [8192];     // captured frame as seen on the write port
  bit          have_prev = 0, exp_short = 0, exp_long = 0, exp_over = 0, checking = 0;
  logic [4:0]  prev_row = '0;
  int          plane_m = 0, busy_until = 0, first_wr = -1, done_cyc = -1, last_issue = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // Compare process: every write and every line completion against the model.
  always @(negedge clk) begin
    logic [18:0] e;
    logic [6:0]  l;
    if (checking) begin
      if (wr_en) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL wr_unexpected: got write addr 0x%0h expected none", wr_addr);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", 32'(wr_addr), 32'(e[18:6]));
          check("wr_data", 32'(wr_data), 32'(e[5:0]));
        end
        mem[wr_addr] = wr_data;
        if (first_wr < 0) first_wr = cyc;
      end
      if (line_done) begin
        if (exp_lines.size() == 0) begin
          tests++; fails++;
          $display("FAIL done_unexpected: got line_done row %0d expected none", line_row);
        end else begin
          l = exp_lines.pop_front();
          check("line_row", 32'(line_row), 32'(l[6:2]));
          check("line_plane", 32'(line_plane), 32'(l[1:0]));
        end
        if (done_cyc < 0) done_cyc = cyc;
      end
`ifdef HUB75_ONTIME_EN
      if (ontime_valid) begin
        on_pulses++;
        last_ontime = int'(ontime);
      end
`endif
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One shift: data valid before the rise, data changes with the rise.
  task automatic shift(input logic [5:0] p);
    if (en) begin
      if (pq.size() >= NCOL) exp_long = 1;
      pq.push_back(p);
    end
    rgb0 = p[5:3]; rgb1 = p[2:0]; lp_clk = 1'b0;
    tick(2);
    lp_clk = 1'b1; rgb0 = ~p[5:3]; rgb1 = ~p[2:0];
    tick(2);
  endtask

  // Latch pulse plus line-level prediction of what the capture must write.
  task automatic do_latch(input logic [4:0] r);
    int n;
    logic [5:0] d;
    if (en) begin
      n = pq.size();
      if (n < NCOL) exp_short = 1;
      if (cyc < busy_until) begin
        exp_over = 1;
      end else begin
        plane_m = (have_prev && r == prev_row) ? (plane_m + 1) % 4 : 0;
        have_prev = 1;
        prev_row = r;
        for (int i = 0; i < NCOL; i++) begin
          if (n >= NCOL)  d = pq[n - NCOL + i];
          else if (i < n) d = pq[i];
          else            d = '0;
          exp_q.push_back({2'(plane_m), r, 6'(i), d});
        end
        exp_lines.push_back({r, 2'(plane_m)});
        busy_until = cyc + NCOL + 2;
      end
      pq.delete();
    end
    last_issue = cyc;
    row = r; latch = 1'b0;
    tick(2);
    latch = 1'b1;
    tick(2);
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || exp_lines.size() != 0) && k < 500) begin
      tick(1);
      k++;
    end
    check({name, "_drained"}, 32'(exp_q.size() + exp_lines.size()), 32'd0);
    tick(4);
  endtask

  task automatic check_flags(input string name);
    check({name, "_err_short"},   32'(err_short),   32'(exp_short));
    check({name, "_err_long"},    32'(err_long),    32'(exp_long));
    check({name, "_err_overrun"}, 32'(err_overrun), 32'(exp_over));
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    exp_short = 0; exp_long = 0; exp_over = 0;
    tick(1);
  endtask

  task automatic set_en(input logic v);
    tick(4);
    en = v;
    if (!v) pq.delete();
    tick(4);
  endtask

  task automatic full_line(input int base);
    for (int c = 0; c < NCOL; c++) shift(6'(base + c));
  endtask

  initial begin
    logic [2:0] c3;
    int t1_issue;
    for (int i = 0; i < 8192; i++) mem[i] = 6'h3F;

    // Reset state
    tick(3);
    check("rst_wr_en",       32'(wr_en),       32'd0);
    check("rst_wr_addr",     32'(wr_addr),     32'd0);
    check("rst_wr_data",     32'(wr_data),     32'd0);
    check("rst_line_done",   32'(line_done),   32'd0);
    check("rst_line_row",    32'(line_row),    32'd0);
    check("rst_line_plane",  32'(line_plane),  32'd0);
    check("rst_err_short",   32'(err_short),   32'd0);
    check("rst_err_long",    32'(err_long),    32'd0);
    check("rst_err_overrun", 32'(err_overrun), 32'd0);
    rst = 1'b0; en = 1'b1; checking = 1;
    tick(2);

    // Full line, row 5: rgb0=col[2:0], rgb1=~col[2:0]
    for (int c = 0; c < NCOL; c++) begin
      c3 = 3'(c);
      shift({c3, ~c3});
    end
    do_latch(5'd5);
    t1_issue = last_issue;
    wait_idle("t1");
    check("t1_lat_first_wr", 32'(first_wr - t1_issue), 32'd3);
    check("t1_lat_done",     32'(done_cyc - first_wr), 32'd65);
    check("t1_mem_col10",    32'(mem[330]),            32'h15);
    check("t1_line_row",     32'(line_row),            32'd5);
    check("t1_line_plane",   32'(line_plane),          32'd0);
    check_flags("t1");

    // Repeated row 5 walks planes 1..3, then row 6 restarts at 0
    for (int k = 0; k < 3; k++) begin
      full_line(k + 1);
      do_latch(5'd5);
      wait_idle("t2");
    end
    check("t2_plane3", 32'(line_plane), 32'd3);
    full_line(20);
    do_latch(5'd6);
    wait_idle("t2b");
    check("t2_row6",       32'(line_row),   32'd6);
    check("t2_row6_plane", 32'(line_plane), 32'd0);

    // Short line: 40 shifts, rest padded with zeros
    for (int c = 0; c < 40; c++) shift(6'(c + 1));
    do_latch(5'd7);
    wait_idle("t3");
    check("t3_mem_col39",  32'(mem[487]),  32'd40);
    check("t3_mem_col50",  32'(mem[498]),  32'd0);
    check("t3_err_short",  32'(err_short), 32'd1);
    check_flags("t3");
    pulse_clr();
    check("t3_clr_short",  32'(err_short), 32'd0);
    check_flags("t3_clr");

    // Long line: 70 shifts keep shifts 7..70
    for (int k = 1; k <= 70; k++) shift(6'(k));
    do_latch(5'd8);
    wait_idle("t4");
    check("t4_mem_col0",  32'(mem[512]), 32'd7);
    check("t4_mem_col63", 32'(mem[575]), 32'd6);
    check("t4_err_long",  32'(err_long), 32'd1);
    check_flags("t4");
    pulse_clr();

    // Overrun: third latch lands while the second line is still draining
    full_line(3);
    do_latch(5'd9);
    full_line(9);
    do_latch(5'd9);
    tick(6);
    do_latch(5'd9);
    wait_idle("t5");
    check("t5_err_overrun", 32'(err_overrun), 32'd1);
    check_flags("t5");
    full_line(33);
    do_latch(5'd9);
    wait_idle("t5b");
    check("t5_plane_kept", 32'(line_plane), 32'd2);
    pulse_clr();

    // en low drops the partial line and ignores edges
    for (int c = 0; c < 20; c++) shift(6'(c + 50));
    set_en(1'b0);
    for (int c = 0; c < 5; c++) shift(6'h2A);
    do_latch(5'd10);
    set_en(1'b1);
    full_line(40);
    do_latch(5'd10);
    wait_idle("t6");
    check("t6_row",   32'(line_row),   32'd10);
    check("t6_plane", 32'(line_plane), 32'd0);
    check_flags("t6");

    // en low during a drain lets the drain finish
    full_line(7);
    do_latch(5'd11);
    set_en(1'b0);
    wait_idle("t7");
    check("t7_row", 32'(line_row), 32'd11);
    set_en(1'b1);
    check_flags("t7");

`ifdef HUB75_ONTIME_EN
    on_pulses = 0;
    do_latch(5'd12);
    wait_idle("on_a");
    noe = 1'b0;
    tick(300);
    noe = 1'b1;
    tick(4);
    do_latch(5'd12);
    wait_idle("on_b");
    check("ontime_value",  32'(last_ontime), 32'd300);
    check("ontime_pulses", 32'(on_pulses),   32'd2);
`endif

    tick(4);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
